// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Single-outstanding instruction fetch FSM with PC, fault capture
//            and accepted-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [63:0] NextPC,
   input  logic        ImemValid,
   input  logic        ImemErr,
   input  logic [31:0] ImemData,
   input  logic        InstrReady,
   output logic        ImemReq,
   output logic [63:0] ImemAddr,
   output logic        InstrValid,
   output logic [31:0] Instruction,
   output logic [63:0] CurrentPC,
   output logic        Fault,
   output logic [1:0]  FaultCause,
   output logic [63:0] FaultAddr,
   output logic [31:0] InstrCount
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_FAULT = 2'd3;

   localparam logic [1:0] C_CAUSE_NONE  = 2'b00;
   localparam logic [1:0] C_CAUSE_MEM   = 2'b01;
   localparam logic [1:0] C_CAUSE_ALIGN = 2'b10;

   logic [1:0]  r_state;
   logic [31:0] r_instr_count;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state       <= S_IDLE;
         CurrentPC     <= RESET_PC;
         Instruction   <= 32'd0;
         r_instr_count <= 32'd0;
         Fault         <= 1'b0;
         FaultCause    <= C_CAUSE_NONE;
         FaultAddr     <= 64'd0;
      end else begin
         case (r_state)
            S_IDLE: r_state <= S_FETCH;
            S_FETCH: begin
               // A memory error wins even when data is flagged valid.
               if (ImemErr) begin
                  r_state    <= S_FAULT;
                  Fault      <= 1'b1;
                  FaultCause <= C_CAUSE_MEM;
                  FaultAddr  <= CurrentPC;
               end else if (ImemValid) begin
                  Instruction <= ImemData;
                  r_state     <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (InstrReady) begin
                  r_instr_count <= r_instr_count + 32'd1;
                  // The instruction itself was consumed; only the target is bad.
                  if (NextPC[1:0] != 2'b00) begin
                     r_state    <= S_FAULT;
                     Fault      <= 1'b1;
                     FaultCause <= C_CAUSE_ALIGN;
                     FaultAddr  <= NextPC;
                  end else begin
                     CurrentPC <= NextPC;
                     r_state   <= S_FETCH;
                  end
               end
            end
            default: r_state <= S_FAULT;
         endcase
      end
   end

   assign ImemReq    = (r_state == S_FETCH);
   assign ImemAddr   = CurrentPC;
   assign InstrValid = (r_state == S_HOLD);
   assign InstrCount = r_instr_count;

endmodule

`default_nettype wire
